tick_scheduler: RTL and testbench

- Shared timebase controller. A single prescaler, shared by all channels, generates a base tick.
- NCH independent channels each divide the base tick by a programmable ratio. Each channel produces a one-cycle enable pulse and a 50%-duty slow clock.
- A valid/ready configuration port programs channels. Changes are applied only on a base-tick boundary, so outputs never glitch.
- Sits between the board clock and any downstream counters, displays or FSMs that need slow rates.

---
 rtl/tick_sched_pkg.sv | 8 +
 rtl/tick_channel.sv | 51 +++++
 rtl/tick_scheduler.sv | 96 +++++++++
 tb/tb_tick_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and default sizing for the tick scheduler.
package tick_sched_pkg;
    localparam int PRESCALE_DEF = 100000;
    localparam int NCH_DEF      = 4;
    localparam int CW_DEF       = 16;

    typedef enum logic {IDLE, PEND} cfg_state_e;
endpackage

// File: rtl/tick_channel.sv
// One divider channel: divides the shared base tick by a programmable ratio,
// producing a one-cycle tick and a 50% duty slow clock.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrap,
    input  logic          apply,
    input  logic          apply_en,
    input  logic [CW-1:0] apply_div,
    output logic          tick,
    output logic          clk_slow,
    output logic          active
);
    logic [CW-1:0] div;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            clk_slow <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            // A config landing on this edge overrides any terminal count.
            if (apply) begin
                cnt      <= '0;
                clk_slow <= 1'b0;
                if (apply_en && apply_div != '0) begin
                    div    <= apply_div;
                    active <= 1'b1;
                end else begin
                    active <= 1'b0;
                end
            end else if (wrap && active) begin
                if (cnt == div - CW'(1)) begin
                    cnt      <= '0;
                    tick     <= 1'b1;
                    clk_slow <= ~clk_slow;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler feeding NCH divider channels; configuration is accepted
// over valid/ready and applied only on a prescaler wrap edge.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int NCH      = NCH_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [CW-1:0]           cfg_div,
    input  logic                    cfg_en,
    output logic                    base_tick,
    output logic [NCH-1:0]          tick_out,
    output logic [NCH-1:0]          clk_slow,
    output logic [NCH-1:0]          ch_active
);
    localparam int PW  = $clog2(PRESCALE);
    localparam int CHW = $clog2(NCH);

    logic [PW-1:0]  pcnt;
    logic           wrap;
    cfg_state_e     state, state_nxt;
    logic [CHW-1:0] pend_ch;
    logic [CW-1:0]  pend_div;
    logic           pend_en;
    logic           accept;
    logic           apply;

    assign wrap = (pcnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt      <= '0;
            base_tick <= 1'b0;
        end else begin
            pcnt      <= wrap ? '0 : pcnt + PW'(1);
            base_tick <= wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend_ch  <= '0;
            pend_div <= '0;
            pend_en  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pend_ch  <= cfg_ch;
                pend_div <= cfg_div;
                pend_en  <= cfg_en;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        accept    = 1'b0;
        apply     = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = !rst;
                accept    = cfg_valid && !rst;
                if (accept) state_nxt = PEND;
            end
            PEND: begin
                if (wrap) begin
                    apply     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(.CW(CW)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wrap      (wrap),
            .apply     (apply && (pend_ch == CHW'(i))),
            .apply_en  (pend_en),
            .apply_div (pend_div),
            .tick      (tick_out[i]),
            .clk_slow  (clk_slow[i]),
            .active    (ch_active[i])
        );
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a closed-form per-cycle scoreboard.
module tb_tick_scheduler;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_en = 1'b0;
    logic       base_tick;
    logic [3:0] tick_out, clk_slow, ch_active;

    int errors = 0;
    int checks = 0;

    tick_scheduler #(.PRESCALE(P), .NCH(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
        .base_tick(base_tick), .tick_out(tick_out), .clk_slow(clk_slow),
        .ch_active(ch_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bt;
        logic [3:0] tk;
        logic [3:0] cs;
        logic [3:0] act;
        bit         pend;
    } exp_t;
    exp_t q[$];

    // Reference state: cyc is the prescaler phase count since reset release.
    int cyc = 0;
    bit pend = 0;
    int pch, pdiv;
    bit pen;
    bit mact[4];
    int app_cyc[4];
    int mdiv[4];

    initial begin
        exp_t e;
        int d, m;
        forever begin
            @(posedge clk);
            if (rst) begin
                pend = 0;
                cyc  = 0;
                for (int i = 0; i < 4; i++) mact[i] = 0;
            end else begin
                if (pend && (cyc % P == P - 1)) begin
                    if (pen && pdiv != 0) begin
                        mact[pch] = 1; app_cyc[pch] = cyc; mdiv[pch] = pdiv;
                    end else begin
                        mact[pch] = 0;
                    end
                    pend = 0;
                end else if (!pend && cfg_valid) begin
                    pend = 1; pch = int'(cfg_ch); pdiv = int'(cfg_div); pen = cfg_en;
                end
                cyc++;
            end
            e.bt   = (cyc > 0) && (cyc % P == 0);
            e.pend = pend;
            e.tk = '0; e.cs = '0; e.act = '0;
            for (int i = 0; i < 4; i++) begin
                if (mact[i]) begin
                    d = cyc - app_cyc[i] - 1;
                    m = d / P;
                    e.act[i] = 1'b1;
                    e.tk[i]  = (d % P == 0) && (m > 0) && (m % mdiv[i] == 0);
                    e.cs[i]  = ((m / mdiv[i]) % 2) == 1;
                end
            end
            q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("base_tick", {3'b0, base_tick}, {3'b0, e.bt});
                chk("tick_out", tick_out, e.tk);
                chk("clk_slow", clk_slow, e.cs);
                chk("ch_active", ch_active, e.act);
                chk("cfg_ready", {3'b0, cfg_ready}, {3'b0, (!e.pend && !rst)});
            end
        end
    end

    // Presents a request and holds it until the handshake completes.
    task automatic cfg(input int ch, input int dv, input bit en);
        bit rdy;
        int n;
        #2;
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(dv); cfg_en = en;
        n = 0;
        do begin
            rdy = cfg_ready;
            @(posedge clk);
            n++;
            if (!rdy) #2;
        end while (!rdy && n < 20);
        checks++;
        assert (rdy) else begin
            errors++;
            $error("FAIL cfg_accept ch=%0d observed=not_accepted expected=accepted_within_20", ch);
        end
    endtask

    task automatic idle(input int n);
        #2;
        cfg_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int a0;
        bit hit;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        idle(12);

        cfg(0, 3, 1'b1);             // ch0 div=3
        idle(60);

        cfg(1, 1, 1'b1);             // ch1 div=1 alongside ch0
        idle(30);

        cfg(2, 5, 1'b1);             // back-to-back, second held through PEND
        cfg(3, 2, 1'b1);
        idle(40);

        // Land a ch0 reconfigure exactly on its terminal-count edge.
        a0  = app_cyc[0];
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(posedge clk);
            #1;
            if ((cyc - a0) % 12 == 10) hit = 1;
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL align_wait observed=no_slot expected=slot_found");
        end
        cfg(0, 2, 1'b1);
        idle(30);

        cfg(2, 0, 1'b1);             // div=0 disables an active channel
        idle(20);

        cfg(1, 4, 1'b1);             // reset while this is pending
        #2 rst = 1'b1;
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        idle(20);

        cfg(3, 1, 1'b1);
        idle(16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
